hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage CPU; sits beside the forwarding unit and covers the hazards forwarding cannot resolve.
- Detects load-use hazards and inserts a one-cycle bubble.
- Flushes wrong-path instructions on a taken branch resolved in MEM.
- Freezes the whole pipeline while data memory is not ready; a timeout watchdog bounds the wait.
- Drives PC, pipeline-register write enables and flushes after reset.

Parameters:
- REG_ADDR_W, 5, register address width
- INIT_CYCLES, 2, cycles of forced flush after reset release (min 1)
- MEM_TIMEOUT, 16, max consecutive memory-wait cycles before the error is raised (min 1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegisterRt  in  REG_ADDR_W  load destination in EX
- IF_ID_RegisterRs  in  REG_ADDR_W  source Rs of instruction in ID
- IF_ID_RegisterRt  in  REG_ADDR_W  source Rt of instruction in ID
- branch_taken_i  in  1  branch in MEM resolved taken
- dmem_req_i  in  1  MEM-stage instruction accesses data memory
- dmem_ready_i  in  1  data memory completes the access this cycle
- PCWrite_o  out  1  PC update enable
- IF_ID_Write_o  out  1  IF/ID register load enable
- pipe_hold_o  out  1  hold ID/EX, EX/MEM, MEM/WB (memory wait)
- IF_ID_Flush_o  out  1  zero IF/ID
- ID_EX_Flush_o  out  1  insert bubble into ID/EX
- EX_MEM_Flush_o  out  1  insert bubble into EX/MEM
- mem_timeout_o  out  1  sticky watchdog error

Behaviour:
- States: INIT, RUN, MEM_WAIT, ERROR.
- Outputs are combinational from the current state plus the current-cycle inputs.
- The state register and counters update on the rising edge of clk_i.
- Reset (rst_i=0 at an edge):
  - state becomes INIT, init counter = 0, wait counter = 0, mem_timeout_o = 0.
  - While in reset or INIT: PCWrite_o=0, IF_ID_Write_o=0, pipe_hold_o=0, all three flushes=1.
  - Reset asserted in any state, including MEM_WAIT, aborts to INIT on the next edge.
- INIT: counts INIT_CYCLES cycles, then moves to RUN.
- RUN: hazard evaluation, priority high to low:
  1. Memory wait: dmem_req_i=1 and dmem_ready_i=0.
     - PCWrite_o=0, IF_ID_Write_o=0, pipe_hold_o=1, no flushes.
     - Next state MEM_WAIT; wait counter = 1.
     - branch_taken_i is ignored this cycle; the branch is re-evaluated when the hold releases, because the MEM stage is frozen.
  2. Branch taken: IF_ID_Flush_o, ID_EX_Flush_o and EX_MEM_Flush_o = 1; PCWrite_o=1 (branch target loads).
     - This overrides any simultaneous load-use stall.
  3. Load-use: ID_EX_MemRead=1, ID_EX_RegisterRt != 0, and ID_EX_RegisterRt equals IF_ID_RegisterRs or IF_ID_RegisterRt.
     - PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1, for exactly one cycle.
     - The load advances, so the condition self-clears.
  4. Otherwise: PCWrite_o=1, IF_ID_Write_o=1, no hold, no flushes.
- MEM_WAIT:
  - Full freeze: PCWrite_o=0, IF_ID_Write_o=0, pipe_hold_o=1.
  - dmem_ready_i=1: pipe_hold_o drops in that same cycle and the pipeline advances; next state RUN; counter cleared.
  - Otherwise the wait counter increments. When the counter reaches MEM_TIMEOUT without ready, set mem_timeout_o=1 and go to ERROR.
- ERROR:
  - Pipeline frozen as in MEM_WAIT.
  - mem_timeout_o stays 1 until reset; ready is ignored.
- Wait counter width: clog2(MEM_TIMEOUT+1); it saturates and never wraps.
- Register 0 never causes a stall.
- dmem_ready_i without dmem_req_i is ignored.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, add three outputs:
  - load_stall_cnt_o (32): load-use bubbles
  - flush_cnt_o (32): taken-branch flush events
  - mem_wait_cnt_o (32): cycles with pipe_hold_o=1
- Counters clear on reset, wrap modulo 2^32 and do not count during INIT.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg:
  - state encoding (INIT=2'd0, RUN=2'd1, MEM_WAIT=2'd2, ERROR=2'd3)
  - REG_ADDR_W default
  - width of the perf counters
- One combinational sub-module, load_use_detect:
  - inputs: MemRead, three register addresses
  - output: hazard
  - reusable by a future branch-in-ID hazard check

Test Plan:
- Reset, then release rst_i: flushes=1 and PCWrite_o=0 for 2 cycles (INIT_CYCLES=2), then PCWrite_o=1 and IF_ID_Write_o=1 with no flushes.
- Load-use: ID_EX_MemRead=1, ID_EX_RegisterRt=5, IF_ID_RegisterRs=5.
  - Exactly one cycle of PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1.
  - Same stimulus with Rt=0: no stall.
- Branch and load-use together: branch_taken_i=1 plus a matching load-use → all three flushes=1, PCWrite_o=1, IF_ID_Write_o not held at 0 by the stall.
- Memory wait: dmem_req_i=1, dmem_ready_i=0 for 3 cycles, then ready=1.
  - pipe_hold_o=1 for 3 cycles, 0 in the ready cycle; state returns to RUN.
  - A branch_taken_i asserted during the hold produces no flush until release.
- Timeout: ready held at 0 for 16 cycles with MEM_TIMEOUT=16 → mem_timeout_o=1, stays 1 after ready=1; clears only after rst_i=0.
- Reset mid-wait: rst_i=0 during MEM_WAIT → next cycle flushes=1, pipe_hold_o=0, mem_timeout_o=0, perf counters (if enabled) = 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERROR    = 2'd3
    } hazardState_e;

    localparam int REG_ADDR_W_DEFAULT = 5;
    localparam int PERF_CNT_W         = 32;

endpackage

// File: rtl/hazard_controller_load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the instruction in ID.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic                  memRead,
    input  logic [REG_ADDR_W-1:0] exRegRt,
    input  logic [REG_ADDR_W-1:0] idRegRs,
    input  logic [REG_ADDR_W-1:0] idRegRt,
    output logic                  hazard
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard = memRead && (exRegRt != '0) &&
                    ((exRegRt == idRegRs) || (exRegRt == idRegRt));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, memory-wait freeze with watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEFAULT,
    parameter int INIT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ID_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRt,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
    input  logic                  branch_taken_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ready_i,
    output logic                  PCWrite_o,
    output logic                  IF_ID_Write_o,
    output logic                  pipe_hold_o,
    output logic                  IF_ID_Flush_o,
    output logic                  ID_EX_Flush_o,
    output logic                  EX_MEM_Flush_o,
`ifdef HAZARD_PERF_CNT_EN
    output logic [PERF_CNT_W-1:0] load_stall_cnt_o,
    output logic [PERF_CNT_W-1:0] flush_cnt_o,
    output logic [PERF_CNT_W-1:0] mem_wait_cnt_o,
`endif
    output logic                  mem_timeout_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    hazardState_e      state, stateNext;
    logic [INIT_W-1:0] initCnt, initCntNext;
    logic [WAIT_W-1:0] waitCnt, waitCntNext;
    logic              memTimeout, memTimeoutNext;
    logic              loadUseHazard;
    logic              evalHazards;
    logic              loadStallEvt;
    logic              flushEvt;

    load_use_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) uLoadUseDetect (
        .memRead (ID_EX_MemRead),
        .exRegRt (ID_EX_RegisterRt),
        .idRegRs (IF_ID_RegisterRs),
        .idRegRt (IF_ID_RegisterRt),
        .hazard  (loadUseHazard)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= INIT;
            initCnt    <= '0;
            waitCnt    <= '0;
            memTimeout <= 1'b0;
        end else begin
            state      <= stateNext;
            initCnt    <= initCntNext;
            waitCnt    <= waitCntNext;
            memTimeout <= memTimeoutNext;
        end
    end

    always_comb begin
        stateNext      = state;
        initCntNext    = initCnt;
        waitCntNext    = waitCnt;
        memTimeoutNext = memTimeout;
        evalHazards    = 1'b0;
        loadStallEvt   = 1'b0;
        flushEvt       = 1'b0;
        PCWrite_o      = 1'b0;
        IF_ID_Write_o  = 1'b0;
        pipe_hold_o    = 1'b0;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Flush_o  = 1'b0;
        EX_MEM_Flush_o = 1'b0;

        case (state)
            INIT: begin
                IF_ID_Flush_o  = 1'b1;
                ID_EX_Flush_o  = 1'b1;
                EX_MEM_Flush_o = 1'b1;
                if (initCnt == INIT_W'(INIT_CYCLES - 1)) begin
                    stateNext   = RUN;
                    initCntNext = '0;
                end else begin
                    initCntNext = initCnt + 1'b1;
                end
            end
            RUN: begin
                // A stalled memory access freezes MEM, so a branch there must wait for release.
                if (dmem_req_i && !dmem_ready_i) begin
                    pipe_hold_o = 1'b1;
                    waitCntNext = WAIT_W'(1);
                    if (MEM_TIMEOUT <= 1) begin
                        stateNext      = ERROR;
                        memTimeoutNext = 1'b1;
                    end else begin
                        stateNext = MEM_WAIT;
                    end
                end else begin
                    evalHazards = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready_i) begin
                    stateNext   = RUN;
                    waitCntNext = '0;
                    evalHazards = 1'b1;
                end else begin
                    pipe_hold_o = 1'b1;
                    if (int'(waitCnt) < MEM_TIMEOUT) begin
                        waitCntNext = waitCnt + 1'b1;
                    end
                    if (int'(waitCnt) + 1 >= MEM_TIMEOUT) begin
                        stateNext      = ERROR;
                        memTimeoutNext = 1'b1;
                    end
                end
            end
            ERROR: begin
                pipe_hold_o = 1'b1;
            end
            default: begin
                stateNext = INIT;
            end
        endcase

        // Branch beats load-use: the flushed ID instruction no longer needs the bubble.
        if (evalHazards) begin
            if (branch_taken_i) begin
                PCWrite_o      = 1'b1;
                IF_ID_Write_o  = 1'b1;
                IF_ID_Flush_o  = 1'b1;
                ID_EX_Flush_o  = 1'b1;
                EX_MEM_Flush_o = 1'b1;
                flushEvt       = 1'b1;
            end else if (loadUseHazard) begin
                ID_EX_Flush_o = 1'b1;
                loadStallEvt  = 1'b1;
            end else begin
                PCWrite_o     = 1'b1;
                IF_ID_Write_o = 1'b1;
            end
        end

        if (!rst_i) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            pipe_hold_o    = 1'b0;
            IF_ID_Flush_o  = 1'b1;
            ID_EX_Flush_o  = 1'b1;
            EX_MEM_Flush_o = 1'b1;
            loadStallEvt   = 1'b0;
            flushEvt       = 1'b0;
        end
    end

    assign mem_timeout_o = memTimeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] loadStallCnt, flushCnt, memWaitCnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            loadStallCnt <= '0;
            flushCnt     <= '0;
            memWaitCnt   <= '0;
        end else begin
            if (loadStallEvt) loadStallCnt <= loadStallCnt + 1'b1;
            if (flushEvt)     flushCnt     <= flushCnt + 1'b1;
            if (pipe_hold_o)  memWaitCnt   <= memWaitCnt + 1'b1;
        end
    end

    assign load_stall_cnt_o = loadStallCnt;
    assign flush_cnt_o      = flushCnt;
    assign mem_wait_cnt_o   = memWaitCnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Table-driven bench for hazard_controller; define HAZARD_PERF_CNT_EN to also check the counters.
module tb_hazard_controller;

    localparam int RW = 5;

    // Expected output bits: {PCWrite, IF_ID_Write, hold, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, timeout}
    localparam logic [6:0] INITV   = 7'b0001110;
    localparam logic [6:0] INITTO  = 7'b0001111;
    localparam logic [6:0] NORMAL  = 7'b1100000;
    localparam logic [6:0] STALL   = 7'b0000100;
    localparam logic [6:0] FLUSH   = 7'b1101110;
    localparam logic [6:0] HOLD    = 7'b0010000;
    localparam logic [6:0] HOLDTO  = 7'b0010001;

    typedef struct {
        string         name;
        logic          rstN;
        logic          memRead;
        logic [RW-1:0] exRt;
        logic [RW-1:0] idRs;
        logic [RW-1:0] idRt;
        logic          branch;
        logic          req;
        logic          ready;
        logic [6:0]    exp;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ID_EX_MemRead;
    logic [RW-1:0] ID_EX_RegisterRt;
    logic [RW-1:0] IF_ID_RegisterRs;
    logic [RW-1:0] IF_ID_RegisterRt;
    logic          branch_taken_i;
    logic          dmem_req_i;
    logic          dmem_ready_i;
    logic          PCWrite_o;
    logic          IF_ID_Write_o;
    logic          pipe_hold_o;
    logic          IF_ID_Flush_o;
    logic          ID_EX_Flush_o;
    logic          EX_MEM_Flush_o;
    logic          mem_timeout_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   load_stall_cnt_o;
    logic [31:0]   flush_cnt_o;
    logic [31:0]   mem_wait_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int expLoadStall = 0;
    int expFlush = 0;
    int expMemWait = 0;
    vec_t vecs[$];

    always #5 clk_i = ~clk_i;

    hazard_controller #(
        .REG_ADDR_W  (RW),
        .INIT_CYCLES (2),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .branch_taken_i   (branch_taken_i),
        .dmem_req_i       (dmem_req_i),
        .dmem_ready_i     (dmem_ready_i),
        .PCWrite_o        (PCWrite_o),
        .IF_ID_Write_o    (IF_ID_Write_o),
        .pipe_hold_o      (pipe_hold_o),
        .IF_ID_Flush_o    (IF_ID_Flush_o),
        .ID_EX_Flush_o    (ID_EX_Flush_o),
        .EX_MEM_Flush_o   (EX_MEM_Flush_o),
`ifdef HAZARD_PERF_CNT_EN
        .load_stall_cnt_o (load_stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o),
        .mem_wait_cnt_o   (mem_wait_cnt_o),
`endif
        .mem_timeout_o    (mem_timeout_o)
    );

    function automatic vec_t mkVec(input string name, input logic rstN, input logic memRead,
                                   input logic [RW-1:0] exRt, input logic [RW-1:0] idRs,
                                   input logic [RW-1:0] idRt, input logic branch,
                                   input logic req, input logic ready, input logic [6:0] exp);
        vec_t v;
        v.name = name; v.rstN = rstN; v.memRead = memRead;
        v.exRt = exRt; v.idRs = idRs; v.idRt = idRt;
        v.branch = branch; v.req = req; v.ready = ready; v.exp = exp;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(posedge clk_i);
        #1;
        rst_i            = v.rstN;
        ID_EX_MemRead    = v.memRead;
        ID_EX_RegisterRt = v.exRt;
        IF_ID_RegisterRs = v.idRs;
        IF_ID_RegisterRt = v.idRt;
        branch_taken_i   = v.branch;
        dmem_req_i       = v.req;
        dmem_ready_i     = v.ready;
    endtask

    task automatic checkOutput(input vec_t v);
        logic [6:0] act;
        @(negedge clk_i);
        act = {PCWrite_o, IF_ID_Write_o, pipe_hold_o, IF_ID_Flush_o,
               ID_EX_Flush_o, EX_MEM_Flush_o, mem_timeout_o};
        checks++;
        if (act !== v.exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b (pc,ifid,hold,fIF,fEX,fMEM,to)",
                     v.name, act, v.exp);
        end
        if (v.rstN && v.exp == STALL) expLoadStall++;
        if (v.rstN && v.exp == FLUSH) expFlush++;
        if (v.exp[4]) expMemWait++;
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput(v);
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic checkCount(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
`endif

    initial begin
        rst_i = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_RegisterRt = '0;
        IF_ID_RegisterRs = '0; IF_ID_RegisterRt = '0; branch_taken_i = 1'b0;
        dmem_req_i = 1'b0; dmem_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        $display("[TB] starting directed vectors");

        //           name               rst mr exRt idRs idRt br req rdy exp
        vecs.push_back(mkVec("reset",         0, 0, 0, 0, 0, 0, 0, 0, INITV));
        vecs.push_back(mkVec("init_0",        1, 0, 0, 0, 0, 0, 0, 0, INITV));
        vecs.push_back(mkVec("init_1",        1, 0, 0, 0, 0, 0, 0, 0, INITV));
        vecs.push_back(mkVec("run_idle",      1, 0, 0, 0, 0, 0, 0, 0, NORMAL));
        vecs.push_back(mkVec("lu_rs",         1, 1, 5, 5, 2, 0, 0, 0, STALL));
        vecs.push_back(mkVec("lu_cleared",    1, 0, 0, 5, 2, 0, 0, 0, NORMAL));
        vecs.push_back(mkVec("lu_reg0",       1, 1, 0, 0, 0, 0, 0, 0, NORMAL));
        vecs.push_back(mkVec("lu_rt",         1, 1, 7, 3, 7, 0, 0, 0, STALL));
        vecs.push_back(mkVec("lu_nomatch",    1, 1, 7, 3, 4, 0, 0, 0, NORMAL));
        vecs.push_back(mkVec("lu_noread",     1, 0, 5, 5, 5, 0, 0, 0, NORMAL));
        vecs.push_back(mkVec("br_over_lu",    1, 1, 5, 5, 0, 1, 0, 0, FLUSH));
        vecs.push_back(mkVec("br_alone",      1, 0, 0, 0, 0, 1, 0, 0, FLUSH));
        vecs.push_back(mkVec("rdy_no_req",    1, 0, 0, 0, 0, 0, 0, 1, NORMAL));
        vecs.push_back(mkVec("wait_1",        1, 0, 0, 0, 0, 0, 1, 0, HOLD));
        vecs.push_back(mkVec("wait_2_br",     1, 0, 0, 0, 0, 1, 1, 0, HOLD));
        vecs.push_back(mkVec("wait_3_br",     1, 0, 0, 0, 0, 1, 1, 0, HOLD));
        vecs.push_back(mkVec("wait_release",  1, 0, 0, 0, 0, 0, 1, 1, NORMAL));
        vecs.push_back(mkVec("br_after_wait", 1, 0, 0, 0, 0, 1, 0, 0, FLUSH));
        vecs.push_back(mkVec("wait_over_all", 1, 1, 5, 5, 0, 1, 1, 0, HOLD));
        vecs.push_back(mkVec("release_2",     1, 0, 0, 0, 0, 0, 1, 1, NORMAL));
        vecs.push_back(mkVec("run_idle_2",    1, 0, 0, 0, 0, 0, 0, 0, NORMAL));

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i]);
        end

`ifdef HAZARD_PERF_CNT_EN
        checkCount("perf_load_stall", load_stall_cnt_o, expLoadStall);
        checkCount("perf_flush", flush_cnt_o, expFlush);
        checkCount("perf_mem_wait", mem_wait_cnt_o, expMemWait);
`endif

        // Watchdog: sixteen not-ready cycles trip the sticky error.
        for (int i = 1; i <= 16; i++) begin
            runVec(mkVec($sformatf("to_wait_%0d", i), 1, 0, 0, 0, 0, 0, 1, 0, HOLD));
        end
        runVec(mkVec("to_error",         1, 0, 0, 0, 0, 0, 1, 0, HOLDTO));
        runVec(mkVec("to_ready_ignored", 1, 0, 0, 0, 0, 1, 1, 1, HOLDTO));
        runVec(mkVec("to_sticky",        1, 1, 5, 5, 0, 1, 0, 0, HOLDTO));
        runVec(mkVec("to_rst_assert",    0, 0, 0, 0, 0, 0, 0, 0, INITTO));
        runVec(mkVec("to_rst_cleared",   0, 0, 0, 0, 0, 0, 0, 0, INITV));
        runVec(mkVec("to_init_0",        1, 0, 0, 0, 0, 0, 0, 0, INITV));
        runVec(mkVec("to_init_1",        1, 0, 0, 0, 0, 0, 0, 0, INITV));
        runVec(mkVec("to_run",           1, 0, 0, 0, 0, 0, 0, 0, NORMAL));

        // Reset taken while the pipeline is frozen on memory.
        runVec(mkVec("mw_wait_1",   1, 0, 0, 0, 0, 0, 1, 0, HOLD));
        runVec(mkVec("mw_wait_2",   1, 0, 0, 0, 0, 0, 1, 0, HOLD));
        runVec(mkVec("mw_rst",      0, 0, 0, 0, 0, 0, 1, 0, INITV));
        runVec(mkVec("mw_rst_hold", 0, 0, 0, 0, 0, 0, 1, 0, INITV));
`ifdef HAZARD_PERF_CNT_EN
        checkCount("perf_rst_load_stall", load_stall_cnt_o, 0);
        checkCount("perf_rst_flush", flush_cnt_o, 0);
        checkCount("perf_rst_mem_wait", mem_wait_cnt_o, 0);
`endif
        runVec(mkVec("mw_init_0",   1, 0, 0, 0, 0, 0, 0, 0, INITV));
        runVec(mkVec("mw_init_1",   1, 0, 0, 0, 0, 0, 0, 0, INITV));
        runVec(mkVec("mw_run",      1, 0, 0, 0, 0, 0, 0, 0, NORMAL));
        runVec(mkVec("mw_lu",       1, 1, 9, 1, 9, 0, 0, 0, STALL));
        runVec(mkVec("mw_lu_clear", 1, 0, 9, 1, 9, 0, 0, 0, NORMAL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
